// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM pipeline stage: memory op codes, FSM state codes,
// byte-lane select constants and op classification helpers.
package mem_stage_pkg;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_LH   = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  // Lane masks; bit 3 is the most significant byte (offset 0, big-endian)
  localparam logic [3:0] SEL_BYTE    = 4'b1000;
  localparam logic [3:0] SEL_HALF_HI = 4'b1100;
  localparam logic [3:0] SEL_HALF_LO = 4'b0011;
  localparam logic [3:0] SEL_WORD    = 4'b1111;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } access_size_e;

  function automatic access_size_e op_size(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      OP_LW, OP_SW:         return SZ_WORD;
      default:              return SZ_NONE;
    endcase
  endfunction

  function automatic logic op_is_load(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_LW);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  function automatic logic op_is_mem(input logic [3:0] op);
    return op_size(op) != SZ_NONE;
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
    case (op_size(op))
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return |addr_lo;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-bus interface between the MEM stage (master) and data memory (slave).
// Handshake: mem_req stays high with stable addr/sel/we/wdata until the cycle mem_ack is high; that cycle completes the transfer.
interface mem_bus_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: store lane select / data replication and
// load lane extraction with sign or zero extension (big-endian lanes).
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sign_ext;
  logic        is_store;

  always_comb begin
    // Offset 0 lives in bits 31:24, so the shift is (3 - offset) bytes
    byte_v      = rdata_i[{~addr_lo_i, 3'b000} +: 8];
    half_v      = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];
    sign_ext    = (op_i == OP_LB) || (op_i == OP_LH);
    is_store    = op_is_store(op_i);
    sel_o       = '0;
    wdata_o     = '0;
    load_data_o = '0;
    case (op_size(op_i))
      SZ_BYTE: begin
        sel_o       = SEL_BYTE >> addr_lo_i;
        wdata_o     = is_store ? {4{store_data_i[7:0]}} : '0;
        load_data_o = {{24{sign_ext & byte_v[7]}}, byte_v};
      end
      SZ_HALF: begin
        sel_o       = addr_lo_i[1] ? SEL_HALF_LO : SEL_HALF_HI;
        wdata_o     = is_store ? {2{store_data_i[15:0]}} : '0;
        load_data_o = {{16{sign_ext & half_v[15]}}, half_v};
      end
      SZ_WORD: begin
        sel_o       = SEL_WORD;
        wdata_o     = is_store ? store_data_i : '0;
        load_data_o = rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Registered MEM stage: byte/half/word loads and stores over a req/ack bus with
// stall, flush and ack watchdog. Optional MEM_ALIGN_CHECK_EN rejects misaligned accesses.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] in_dest_addr,
  input  logic                  in_wreg,
  input  logic [31:0]           in_wdata,
  input  logic [3:0]            in_mem_op,
  input  logic [31:0]           in_mem_addr,
  input  logic [31:0]           in_store_data,
  input  logic                  in_hilo_we,
  input  logic [31:0]           in_hi,
  input  logic [31:0]           in_lo,
  output logic                  stall_req,
  mem_bus_if.master             bus,
  output logic                  out_valid,
  output logic [REG_ADDR_W-1:0] out_dest_addr,
  output logic                  out_wreg,
  output logic [31:0]           out_wdata,
  output logic                  out_hilo_we,
  output logic [31:0]           out_hi,
  output logic [31:0]           out_lo,
  output logic                  out_bus_err,
  output logic [0:0]            dbg_state
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  flushed_q, flushed_d;

  logic [3:0]            op_q;
  logic [31:0]           addr_q, sdata_q, wdata_q, hi_q, lo_q;
  logic [REG_ADDR_W-1:0] dest_q;
  logic                  wreg_q, hilo_we_q;

  logic                  out_valid_q, out_valid_d;
  logic [REG_ADDR_W-1:0] out_dest_q, out_dest_d;
  logic                  out_wreg_q, out_wreg_d;
  logic [31:0]           out_wdata_q, out_wdata_d;
  logic                  out_hilo_we_q, out_hilo_we_d;
  logic [31:0]           out_hi_q, out_hi_d, out_lo_q, out_lo_d;
  logic                  out_bus_err_q, out_bus_err_d;

  logic        busy, accept, in_is_mem, in_misaligned, start;
  logic [3:0]  lane_sel;
  logic [31:0] lane_wdata, lane_load;

`ifdef MEM_ALIGN_CHECK_EN
  assign in_misaligned = op_misaligned(in_mem_op, in_mem_addr[1:0]);
`else
  assign in_misaligned = 1'b0;
`endif

  assign busy      = (state_q == ST_BUSY);
  assign accept    = !busy && in_valid && !flush;
  assign in_is_mem = op_is_mem(in_mem_op);
  assign start     = accept && in_is_mem && !in_misaligned;
  // Gated with rst so the combinational stall term is also low while in reset
  assign stall_req = rst && (start || busy);

  mem_lane_align u_lane (
    .op_i         (op_q),
    .addr_lo_i    (addr_q[1:0]),
    .store_data_i (sdata_q),
    .rdata_i      (bus.mem_rdata),
    .sel_o        (lane_sel),
    .wdata_o      (lane_wdata),
    .load_data_o  (lane_load)
  );

  assign bus.mem_req   = busy;
  assign bus.mem_we    = busy && op_is_store(op_q);
  assign bus.mem_addr  = busy ? {addr_q[31:2], 2'b00} : '0;
  assign bus.mem_sel   = busy ? lane_sel : '0;
  assign bus.mem_wdata = busy ? lane_wdata : '0;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    flushed_d     = flushed_q;
    out_valid_d   = 1'b0;
    out_dest_d    = '0;
    out_wreg_d    = 1'b0;
    out_wdata_d   = '0;
    out_hilo_we_d = 1'b0;
    out_hi_d      = '0;
    out_lo_d      = '0;
    out_bus_err_d = 1'b0;
    if (!busy) begin
      if (accept) begin
        if (in_misaligned) begin
          out_bus_err_d = 1'b1;
        end else if (in_is_mem) begin
          state_d   = ST_BUSY;
          cnt_d     = '0;
          flushed_d = 1'b0;
        end else begin
          out_valid_d   = 1'b1;
          out_dest_d    = in_dest_addr;
          out_wreg_d    = in_wreg;
          out_wdata_d   = in_wdata;
          out_hilo_we_d = in_hilo_we;
          out_hi_d      = in_hi;
          out_lo_d      = in_lo;
        end
      end
    end else if (bus.mem_ack) begin
      state_d = ST_IDLE;
      // A flush seen at any point of the transfer discards its result
      if (!(flushed_q || flush)) begin
        out_valid_d   = 1'b1;
        out_dest_d    = dest_q;
        out_wreg_d    = wreg_q && op_is_load(op_q);
        out_wdata_d   = op_is_load(op_q) ? lane_load : wdata_q;
        out_hilo_we_d = hilo_we_q;
        out_hi_d      = hi_q;
        out_lo_d      = lo_q;
      end
    end else if (cnt_q == CNT_LAST) begin
      state_d       = ST_IDLE;
      out_bus_err_d = 1'b1;
    end else begin
      cnt_d     = cnt_q + 1'b1;
      flushed_d = flushed_q || flush;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      flushed_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_dest_q    <= '0;
      out_wreg_q    <= 1'b0;
      out_wdata_q   <= '0;
      out_hilo_we_q <= 1'b0;
      out_hi_q      <= '0;
      out_lo_q      <= '0;
      out_bus_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      flushed_q     <= flushed_d;
      out_valid_q   <= out_valid_d;
      out_dest_q    <= out_dest_d;
      out_wreg_q    <= out_wreg_d;
      out_wdata_q   <= out_wdata_d;
      out_hilo_we_q <= out_hilo_we_d;
      out_hi_q      <= out_hi_d;
      out_lo_q      <= out_lo_d;
      out_bus_err_q <= out_bus_err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= OP_NONE;
      addr_q    <= '0;
      sdata_q   <= '0;
      wdata_q   <= '0;
      dest_q    <= '0;
      wreg_q    <= 1'b0;
      hilo_we_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else if (start) begin
      op_q      <= in_mem_op;
      addr_q    <= in_mem_addr;
      sdata_q   <= in_store_data;
      wdata_q   <= in_wdata;
      dest_q    <= in_dest_addr;
      wreg_q    <= in_wreg;
      hilo_we_q <= in_hilo_we;
      hi_q      <= in_hi;
      lo_q      <= in_lo;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_dest_addr = out_dest_q;
  assign out_wreg      = out_wreg_q;
  assign out_wdata     = out_wdata_q;
  assign out_hilo_we   = out_hilo_we_q;
  assign out_hi        = out_hi_q;
  assign out_lo        = out_lo_q;
  assign out_bus_err   = out_bus_err_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed plan items plus random transactions, checked
// against a transaction-level model of lanes, extension, timeout and flush.
module tb_mem_access_stage;

  localparam int TMO = 16;

  logic        clk;
  logic        rst;
  logic        in_valid, flush, in_wreg, in_hilo_we;
  logic [4:0]  in_dest_addr;
  logic [31:0] in_wdata, in_mem_addr, in_store_data, in_hi, in_lo;
  logic [3:0]  in_mem_op;
  logic        stall_req, out_valid, out_wreg, out_hilo_we, out_bus_err;
  logic [4:0]  out_dest_addr;
  logic [31:0] out_wdata, out_hi, out_lo;
  logic [0:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  mem_bus_if bus ();

  mem_access_stage #(.REG_ADDR_W(5), .ACK_TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .flush         (flush),
    .in_dest_addr  (in_dest_addr),
    .in_wreg       (in_wreg),
    .in_wdata      (in_wdata),
    .in_mem_op     (in_mem_op),
    .in_mem_addr   (in_mem_addr),
    .in_store_data (in_store_data),
    .in_hilo_we    (in_hilo_we),
    .in_hi         (in_hi),
    .in_lo         (in_lo),
    .stall_req     (stall_req),
    .bus           (bus),
    .out_valid     (out_valid),
    .out_dest_addr (out_dest_addr),
    .out_wreg      (out_wreg),
    .out_wdata     (out_wdata),
    .out_hilo_we   (out_hilo_we),
    .out_hi        (out_hi),
    .out_lo        (out_lo),
    .out_bus_err   (out_bus_err),
    .dbg_state     (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  function automatic int acc_bytes(input logic [3:0] op);
    if (op == 1 || op == 2 || op == 6) return 1;
    if (op == 3 || op == 4 || op == 7) return 2;
    if (op == 5 || op == 8) return 4;
    return 0;
  endfunction

  function automatic int first_lane(input logic [3:0] op, input logic [31:0] addr);
    int n = acc_bytes(op);
    return (int'(addr % 4) / n) * n;
  endfunction

  function automatic logic [31:0] m_sel(input logic [3:0] op, input logic [31:0] addr);
    logic [31:0] s = 0;
    int n = acc_bytes(op);
    int f = first_lane(op, addr);
    for (int i = 0; i < n; i++) s = s + (32'd1 << (3 - (f + i)));
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
    int n = acc_bytes(op);
    if (n == 1) return (d % 256) * 32'h0101_0101;
    if (n == 2) return (d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr,
                                         input logic [31:0] rdata);
    int n = acc_bytes(op);
    int f = first_lane(op, addr);
    logic [31:0] v;
    if (n == 4) return rdata;
    v = (rdata >> (8 * (4 - f - n))) % (32'd1 << (8 * n));
    if ((op == 1 || op == 3) && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  task automatic idle_inputs();
    in_valid = 0; flush = 0; in_dest_addr = 0; in_wreg = 0; in_wdata = 0;
    in_mem_op = 0; in_mem_addr = 0; in_store_data = 0; in_hilo_we = 0;
    in_hi = 0; in_lo = 0;
  endtask

  // One instruction from acceptance to the cycle after its writeback pulse.
  // ack_at / flush_at are BUSY-cycle indices; -1 means never.
  task automatic run_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int ack_at, input int flush_at, input logic [4:0] dest,
                         input logic wreg, input logic hwe);
    logic        is_mem, is_ld, is_st, mis, flushed, acked, tmo, vld;
    logic [31:0] hi, lo;
    hi = $urandom(); lo = $urandom();
    is_mem = acc_bytes(op) != 0;
    is_ld  = op >= 1 && op <= 5;
    is_st  = op >= 6 && op <= 8;
    mis = 0; flushed = 0; acked = 0; tmo = 0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = is_mem && (addr % acc_bytes(op) != 0);
`endif
    in_valid = 1; in_mem_op = op; in_mem_addr = addr; in_store_data = sdata;
    in_wdata = wdata; in_dest_addr = dest; in_wreg = wreg; in_hilo_we = hwe;
    in_hi = hi; in_lo = lo; flush = 0;
    #1;
    chk("stall_accept", stall_req, is_mem && !mis);
    chk("req_idle", bus.mem_req, 0);
    @(posedge clk); @(negedge clk);
    if (is_mem && !mis) begin
      for (int c = 0; c < TMO; c++) begin
        flush = (c == flush_at);
        bus.mem_ack = (c == ack_at);
        bus.mem_rdata = (c == ack_at) ? rdata : $urandom();
        #1;
        chk("busy_req", bus.mem_req, 1);
        chk("busy_addr", bus.mem_addr, addr - (addr % 4));
        chk("busy_sel", bus.mem_sel, m_sel(op, addr));
        chk("busy_we", bus.mem_we, is_st);
        if (is_st) chk("busy_wdata", bus.mem_wdata, m_wdata(op, sdata));
        chk("busy_stall", stall_req, 1);
        chk("busy_out_valid", out_valid, 0);
        if (c == flush_at) flushed = 1;
        acked = (c == ack_at);
        tmo = !acked && (c == TMO - 1);
        @(posedge clk); @(negedge clk);
        if (acked || tmo) break;
      end
    end
    idle_inputs();
    bus.mem_ack = 0;
    #1;
    vld = !is_mem || (acked && !flushed);
    chk("done_valid", out_valid, vld);
    chk("done_wreg", out_wreg, vld && wreg && !is_st);
    chk("done_hilo_we", out_hilo_we, vld && hwe);
    chk("done_bus_err", out_bus_err, mis || tmo);
    chk("done_req", bus.mem_req, 0);
    chk("done_stall", stall_req, 0);
    if (vld) begin
      chk("done_wdata", out_wdata, is_ld ? m_load(op, addr, rdata) : wdata);
      chk("done_dest", out_dest_addr, dest);
      if (hwe) begin
        chk("done_hi", out_hi, hi);
        chk("done_lo", out_lo, lo);
      end
    end
    @(posedge clk); @(negedge clk);
    chk("pulse_valid", out_valid, 0);
    chk("pulse_bus_err", out_bus_err, 0);
  endtask

  initial begin
    logic [3:0]  r_op;
    int          r_ack, r_flush;

    rst = 0;
    idle_inputs();
    bus.mem_ack = 0;
    bus.mem_rdata = 0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_wdata", out_wdata, 0);
    chk("rst_out_bus_err", out_bus_err, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_sel", bus.mem_sel, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_state", dbg_state, 0);
    @(negedge clk);
    rst = 1;
    @(negedge clk);

    // Directed plan items
    run_txn(4'd0, 32'h0, 32'h0, 32'h1234_5678, 32'h0, -1, -1, 5'd3, 1'b1, 1'b0);
    run_txn(4'd1, 32'h101, 32'h0, 32'h0, 32'h11F2_3344, 2, -1, 5'd7, 1'b1, 1'b0);
    run_txn(4'd2, 32'h101, 32'h0, 32'h0, 32'h11F2_3344, 2, -1, 5'd7, 1'b1, 1'b0);
    run_txn(4'd7, 32'h202, 32'h0000_ABCD, 32'h55, 32'h0, 0, -1, 5'd9, 1'b1, 1'b0);
    run_txn(4'd5, 32'h300, 32'h0, 32'h0, 32'h0, -1, -1, 5'd4, 1'b1, 1'b0);
    run_txn(4'd5, 32'h400, 32'h0, 32'h0, 32'hDEAD_BEEF, 3, 1, 5'd5, 1'b1, 1'b1);
    run_txn(4'd5, 32'h3, 32'h0, 32'h0, 32'hCAFE_F00D, 1, -1, 5'd6, 1'b1, 1'b0);
    run_txn(4'd3, 32'h10, 32'h0, 32'h0, 32'h8001_7F00, 0, -1, 5'd1, 1'b1, 1'b0);
    run_txn(4'd4, 32'h12, 32'h0, 32'h0, 32'h1234_F00D, 1, -1, 5'd2, 1'b1, 1'b0);
    run_txn(4'd6, 32'h23, 32'h0000_00A5, 32'h77, 32'h0, 0, -1, 5'd8, 1'b1, 1'b0);
    run_txn(4'd8, 32'h30, 32'h89AB_CDEF, 32'h0, 32'h0, 4, -1, 5'd0, 1'b0, 1'b1);
    run_txn(4'd9, 32'h44, 32'h0, 32'hA5A5_5A5A, 32'h0, -1, -1, 5'd31, 1'b1, 1'b1);
    run_txn(4'd5, 32'h500, 32'h0, 32'h0, 32'h0102_0304, 15, -1, 5'd10, 1'b1, 1'b0);

    // An ack while idle must be ignored
    bus.mem_ack = 1;
    @(posedge clk); @(negedge clk);
    bus.mem_ack = 0;
    #1;
    chk("idle_ack_valid", out_valid, 0);
    chk("idle_ack_req", bus.mem_req, 0);
    chk("idle_ack_state", dbg_state, 0);

    // Random transactions
    for (int k = 0; k < 40; k++) begin
      r_op = 4'($urandom_range(0, 10));
      r_ack = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
      r_flush = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_txn(r_op, $urandom(), $urandom(), $urandom(), $urandom(), r_ack, r_flush,
              5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset asserted in the middle of a transfer
    in_valid = 1; in_mem_op = 4'd5; in_mem_addr = 32'h600; in_wreg = 1; in_dest_addr = 5'd12;
    @(posedge clk); @(negedge clk);
    #1;
    chk("pre_rst_req", bus.mem_req, 1);
    @(posedge clk);
    #2;
    rst = 0;
    #1;
    chk("async_rst_req", bus.mem_req, 0);
    chk("async_rst_sel", bus.mem_sel, 0);
    chk("async_rst_stall", stall_req, 0);
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_state", dbg_state, 0);
    @(negedge clk);
    idle_inputs();
    rst = 1;
    @(posedge clk); @(negedge clk);
    chk("post_rst_req", bus.mem_req, 0);
    chk("post_rst_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Parametrised MEM stage of the five-stage MIPS pipeline, between the execute stage and writeback. Unlike the pass-through stage it replaces, it registers its outputs, performs byte/half/word loads and stores over a variable-latency req/ack data bus, and stalls the pipeline while an access is outstanding. Register-file and HI/LO write information is carried alongside, and a watchdog aborts hung bus transfers.

## Interface
- REG_ADDR_W, 5: destination register address width
- ACK_TIMEOUT, 16: cycles a bus request may wait for `mem_ack` before abort (must be ≥2)
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  execute stage presents an instruction
- flush  in  1  squash the current instruction
- in_dest_addr  in  REG_ADDR_W  GPR destination
- in_wreg  in  1  GPR write enable
- in_wdata  in  32  ALU result (GPR data for non-load ops)
- in_mem_op  in  4  NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8; others are treated as NONE
- in_mem_addr  in  32  effective address
- in_store_data  in  32  store source register value
- in_hilo_we, in_hi, in_lo  in  1/32/32  HI/LO write request
- stall_req  out  1  upstream must hold all in_* stable
- mem_req, mem_we  out  1/1  bus request, write
- mem_addr  out  32  word address (bits 1:0 forced to 0)
- mem_sel  out  4  byte lanes; bit 3 = bits 31:24
- mem_wdata  out  32  lane-steered store data
- mem_rdata, mem_ack  in  32/1  read data, transfer done
- out_valid, out_dest_addr, out_wreg, out_wdata  out  registered writeback fields
- out_hilo_we, out_hi, out_lo  out  registered HI/LO fields
- out_bus_err  out  1  one-cycle pulse on timeout (or misalignment, see Configuration)

## Operation
- Byte order: big-endian; byte offset 0 maps to bits 31:24.
- States: IDLE, BUSY.
- IDLE, in_valid=1, flush=0, op=NONE: all fields latched into the output register; out_valid=1 next cycle.
- IDLE, in_valid=1, flush=0, load/store op: latch the request, go to BUSY, reset the timeout counter to 0.
- BUSY: mem_req=1 with stable addr/sel/we/wdata. The counter increments each cycle without ack.
- BUSY ack: loads extract the lane(s), sign- or zero-extend them, and write the result to out_wdata. Stores pass in_wdata through with out_wreg forced to 0. out_valid=1 next cycle; return to IDLE.
- BUSY counter reaches ACK_TIMEOUT-1 without ack: drop mem_req, go to IDLE, out_valid=0, out_bus_err pulse.
- Sel: SB/LB → 1000>>addr[1:0]; SH/LH → 1100 (addr[1]=0) or 0011; SW/LW → 1111.
- Store data is replicated into every lane: byte ×4, half ×2.
- stall_req = (IDLE & in_valid & memop & ~flush) | BUSY.
- flush in IDLE: instruction dropped, out_valid=0.
- flush in BUSY: the bus transfer completes or times out, but its result is discarded (out_valid=0, no writes). flush takes priority over in_valid.
- Outputs not accepting a new instruction that cycle are registered as out_valid=0, out_wreg=0, out_hilo_we=0.

## Timing
- Reset (rst=0): state IDLE, counter 0, and every output 0: out_*, mem_*, stall_req, out_bus_err.
- Reset asserted mid-transfer aborts at once; mem_req deasserts asynchronously.
- Non-memory latency: 1 cycle.
- Memory latency: 1 + (cycles until ack) cycles; minimum 2 (ack on the first BUSY cycle).
- mem_ack sampled only in BUSY; an ack in IDLE is ignored.
- An ack arriving in the timeout cycle counts as success.
- The output register updates every cycle, so out_* fields are single-cycle pulses.

## Configuration
- MEM_ALIGN_CHECK_EN defined: misaligned LH/LHU/SH (addr[0]≠0) and LW/SW (addr[1:0]≠0) issue no bus request. The instruction completes in 1 cycle with out_valid=0, out_wreg=0 and an out_bus_err pulse.
- MEM_ALIGN_CHECK_EN undefined: low address bits are ignored (half offset uses addr[1] only), with no error.

## Structure
- Package mem_stage_pkg: mem_op encodings, state encoding, lane-select constants.
- Sub-module mem_lane_align: combinational store steering (mem_sel, mem_wdata) and load extraction/extension. It is instantiated once.

## Test plan
- Non-memory op, in_wdata=0x12345678, dest=3, wreg=1 → next cycle out_valid=1, out_wdata=0x12345678, stall_req never set.
- LB addr=0x101, rdata=0x11F23344, ack after 3 BUSY cycles → mem_sel=0100, out_wdata=0xFFFFFFF2. With LBU the result is 0x000000F2; stall_req stays high 4 cycles.
- SH addr=0x202, store=0x0000ABCD → mem_addr=0x200, mem_sel=0011, mem_wdata=0xABCDABCD, mem_we=1, out_wreg=0.
- No ack for ACK_TIMEOUT=16 cycles → mem_req drops after 16 BUSY cycles, one out_bus_err pulse, out_valid=0, stall released.
- flush during BUSY, then ack with LW rdata=0xDEADBEEF → out_valid=0, no GPR write.
- With MEM_ALIGN_CHECK_EN, LW addr=0x3 → no mem_req, out_bus_err pulse next cycle. rst=0 mid-BUSY → all outputs 0 immediately.
